// File: rtl/mailer_pkg.sv
// Shared types and constants for the packet mailer: FSM states,
// default header bytes and the smallest legal packet length.
package mailer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        CHECK  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [7:0] DEF_START_BYTE = 8'hAA;
    localparam logic [7:0] DEF_NODE_ADR   = 8'h01;
    localparam logic [7:0] DEF_BCAST_ADR  = 8'hFF;
    localparam int         MIN_LEN        = 4;

endpackage

// File: rtl/mailer_cksum.sv
// Additive checksum accumulator, wraps modulo 2**DATA_W.
module mailer_cksum
    import mailer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            sum <= '0;
        else if (en)
            sum <= sum + data;
    end

endmodule

// File: rtl/packet_mailer.sv
// Copies a packet from a source RAM to a destination RAM while checking
// start byte, address, optional length field and additive checksum.
module packet_mailer
    import mailer_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 8,
    parameter int                PKT_LEN    = 256,
    parameter logic [DATA_W-1:0] START_BYTE = DATA_W'(DEF_START_BYTE),
    parameter logic [DATA_W-1:0] NODE_ADR   = DATA_W'(DEF_NODE_ADR),
    parameter logic [DATA_W-1:0] BCAST_ADR  = DATA_W'(DEF_BCAST_ADR),
    parameter bit                LEN_MODE   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] src_adr,
    input  logic [DATA_W-1:0] src_data,
    output logic [ADDR_W-1:0] dst_adr,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_we,
    output logic              busy,
    output logic              done,
    output logic              run,
    output logic              bcast,
    output logic              err_start,
    output logic              err_adr,
    output logic              err_len,
    output logic              err_crc,
    output logic [ADDR_W:0]   pkt_len
);

    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] TWO     = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0] LEN_FIX = (ADDR_W+1)'(PKT_LEN);

    state_t            state;
    logic [ADDR_W:0]   rd_nxt;
    logic [ADDR_W:0]   len_r;
    logic              iss;
    logic              len_bad;
    logic [DATA_W-1:0] first_r, adr_r, crc_r, sum;

    logic [ADDR_W:0] wr_idx, cur_len;
    logic            len_hit, len_inv, is_last, acc_en;
    logic            bad_start, is_bcast, bad_adr, bad_crc;

    // The length word is usable on the very cycle it arrives, so address
    // issue and last-word detection already honour it.
    assign wr_idx  = {1'b0, dst_adr};
    assign len_hit = LEN_MODE && dst_we && (wr_idx == TWO);
    assign len_inv = len_hit && ((32'(src_data) < 32'(MIN_LEN)) ||
                                 (32'(src_data) > 32'(PKT_LEN)));
    assign cur_len = len_hit ? (ADDR_W+1)'(src_data) : len_r;
    assign is_last = dst_we && (wr_idx == cur_len - ONE);
    assign acc_en  = dst_we && !is_last;

    assign dst_data = dst_we ? src_data : '0;

    assign bad_start = (first_r != START_BYTE);
    assign is_bcast  = (adr_r == BCAST_ADR);
    assign bad_adr   = !is_bcast && (adr_r != NODE_ADR);
    assign bad_crc   = !len_bad && (sum != crc_r);

    mailer_cksum #(.DATA_W(DATA_W)) u_cksum (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state == IDLE) && start),
        .en   (acc_en),
        .data (src_data),
        .sum  (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            src_adr   <= '0;
            dst_adr   <= '0;
            dst_we    <= 1'b0;
            rd_nxt    <= '0;
            len_r     <= '0;
            iss       <= 1'b0;
            len_bad   <= 1'b0;
            first_r   <= '0;
            adr_r     <= '0;
            crc_r     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            run       <= 1'b0;
            bcast     <= 1'b0;
            err_start <= 1'b0;
            err_adr   <= 1'b0;
            err_len   <= 1'b0;
            err_crc   <= 1'b0;
            pkt_len   <= '0;
        end else begin
            done   <= 1'b0;
            run    <= 1'b0;
            dst_we <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= READ;
                    busy      <= 1'b1;
                    src_adr   <= '0;
                    rd_nxt    <= ONE;
                    iss       <= 1'b1;
                    len_r     <= LEN_FIX;
                    len_bad   <= 1'b0;
                    first_r   <= '0;
                    adr_r     <= '0;
                    crc_r     <= '0;
                    bcast     <= 1'b0;
                    err_start <= 1'b0;
                    err_adr   <= 1'b0;
                    err_len   <= 1'b0;
                    err_crc   <= 1'b0;
                    pkt_len   <= '0;
                end
                READ: begin
                    // iss marks that src_adr holds a live read; its data lands next cycle
                    dst_we  <= iss && !len_inv;
                    dst_adr <= src_adr;
                    if (rd_nxt < cur_len) begin
                        src_adr <= rd_nxt[ADDR_W-1:0];
                        rd_nxt  <= rd_nxt + ONE;
                        iss     <= 1'b1;
                    end else begin
                        iss <= 1'b0;
                    end
                    if (dst_we && wr_idx == '0) first_r <= src_data;
                    if (dst_we && wr_idx == ONE) adr_r <= src_data;
                    if (len_hit) len_r <= cur_len;
                    if (is_last) crc_r <= src_data;
                    if (len_inv) begin
                        len_bad <= 1'b1;
                        iss     <= 1'b0;
                        state   <= CHECK;
                    end else if (is_last) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    err_start <= bad_start;
                    err_adr   <= bad_adr;
                    err_len   <= len_bad;
                    err_crc   <= bad_crc;
                    bcast     <= is_bcast;
                    pkt_len   <= len_r;
                    done      <= 1'b1;
                    run       <= !(bad_start || bad_adr || len_bad || bad_crc);
                    busy      <= 1'b0;
                    state     <= REPORT;
                end
                REPORT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_mailer.sv
// Bench for packet_mailer: fixed-length instance u0 and length-field
// instance u1, each with its own source RAM model.
module tb_packet_mailer;

    typedef struct {
        bit run, bcast, es, ea, el, ec;
        int lat, wr, plen;
    } exp_t;

    typedef struct {
        int   d;
        int   b0, b1, b2, n;
        bit   bad;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       start = '0;
    logic [1:0][7:0]  sa, sd, da, dd;
    logic [1:0]       we, busy, done, run, bcast, es, ea, el, ec;
    logic [1:0][8:0]  plen;
    logic [7:0]       smem [2][256];

    int ntests = 0;
    int nfail  = 0;

    packet_mailer #(.PKT_LEN(256), .LEN_MODE(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .src_adr(sa[0]), .src_data(sd[0]),
        .dst_adr(da[0]), .dst_data(dd[0]), .dst_we(we[0]),
        .busy(busy[0]), .done(done[0]), .run(run[0]), .bcast(bcast[0]),
        .err_start(es[0]), .err_adr(ea[0]), .err_len(el[0]), .err_crc(ec[0]),
        .pkt_len(plen[0])
    );

    packet_mailer #(.PKT_LEN(32), .LEN_MODE(1'b1)) u1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .src_adr(sa[1]), .src_data(sd[1]),
        .dst_adr(da[1]), .dst_data(dd[1]), .dst_we(we[1]),
        .busy(busy[1]), .done(done[1]), .run(run[1]), .bcast(bcast[1]),
        .err_start(es[1]), .err_adr(ea[1]), .err_len(el[1]), .err_crc(ec[1]),
        .pkt_len(plen[1])
    );

    always @(posedge clk)
        for (int i = 0; i < 2; i++) sd[i] <= smem[i][sa[i]];

    task automatic chk(input string nm, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: actual %0d expected %0d", nm, act, exp);
        end
    endtask

    // Random payload, fixed header bytes, checksum in word n-1 (optionally off by one).
    task automatic build(input int d, input int b0, input int b1, input int b2,
                         input int n, input bit bad);
        int s;
        for (int i = 0; i < 256; i++) smem[d][i] = 8'($urandom_range(255));
        smem[d][0] = 8'(b0);
        smem[d][1] = 8'(b1);
        if (d == 1) smem[d][2] = 8'(b2);
        s = 0;
        for (int i = 0; i < n - 1; i++) s += int'(smem[d][i]);
        smem[d][n-1] = 8'(s + (bad ? 1 : 0));
    endtask

    // Expected outcome straight from the packet contents.
    function automatic exp_t model(input int d);
        exp_t e;
        int L, s, maxl;
        maxl    = d ? 32 : 256;
        L       = d ? int'(smem[d][2]) : 256;
        e.el    = (d == 1) && (L < 4 || L > maxl);
        e.plen  = L;
        e.es    = smem[d][0] != 8'hAA;
        e.bcast = smem[d][1] == 8'hFF;
        e.ea    = !e.bcast && smem[d][1] != 8'h01;
        if (e.el) begin
            e.lat = 6; e.wr = 3; e.ec = 1'b0;
        end else begin
            s = 0;
            for (int i = 0; i < L - 1; i++) s += int'(smem[d][i]);
            e.ec  = (s % 256) != int'(smem[d][L-1]);
            e.lat = L + 3;
            e.wr  = L;
        end
        e.run = !(e.es || e.ea || e.el || e.ec);
        return e;
    endfunction

    // One packet: start pulse, watch every write, check report. pulse_at>0
    // re-pulses start at that cycle while the mailer is busy.
    task automatic run_pkt(input int d, input exp_t e, input string tag, input int pulse_at);
        int cyc, nwr, wr_err, lat, extra;
        bit r_run, r_bc, r_es, r_ea, r_el, r_ec;
        @(negedge clk) start[d] = 1'b1;
        @(negedge clk) start[d] = 1'b0;
        cyc = 1;
        chk({tag, ".busy_t1"}, busy[d], 1);
        chk({tag, ".src_adr_t1"}, sa[d], 0);
        chk({tag, ".flags_clr_t1"}, {bcast[d], es[d], ea[d], el[d], ec[d], plen[d]}, 0);
        nwr = 0; wr_err = 0; lat = -1;
        {r_run, r_bc, r_es, r_ea, r_el, r_ec} = '0;
        while (cyc < 600 && lat < 0) begin
            @(negedge clk);
            cyc++;
            start[d] = (cyc == pulse_at);
            if (we[d]) begin
                if (da[d] != 8'(nwr) || dd[d] != smem[d][nwr]) wr_err++;
                nwr++;
            end
            if (done[d]) begin
                lat = cyc;
                {r_run, r_bc, r_es, r_ea, r_el, r_ec} =
                    {run[d], bcast[d], es[d], ea[d], el[d], ec[d]};
                chk({tag, ".busy_at_done"}, busy[d], 0);
            end
        end
        start[d] = 1'b0;
        chk({tag, ".done_lat"}, lat, e.lat);
        chk({tag, ".run"}, r_run, e.run);
        chk({tag, ".bcast"}, r_bc, e.bcast);
        chk({tag, ".err_start"}, r_es, e.es);
        chk({tag, ".err_adr"}, r_ea, e.ea);
        chk({tag, ".err_len"}, r_el, e.el);
        chk({tag, ".err_crc"}, r_ec, e.ec);
        chk({tag, ".pkt_len"}, plen[d], e.plen);
        chk({tag, ".writes"}, nwr, e.wr);
        chk({tag, ".write_data"}, wr_err, 0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy[d] || done[d] || run[d] || we[d]) extra++;
        end
        chk({tag, ".idle_after"}, extra, 0);
        chk({tag, ".flags_held"}, {es[d], ea[d], el[d], ec[d]}, {e.es, e.ea, e.el, e.ec});
    endtask

    vec_t vecs[9];

    initial begin
        vec_t v;
        exp_t e;
        int d, b0, b1, L, n, cyc, bad;

        vecs[0] = '{0, 'hAA, 'h01, 0, 256, 0, '{1, 0, 0, 0, 0, 0, 259, 256, 256}};
        vecs[1] = '{0, 'hAA, 'h01, 0, 256, 1, '{0, 0, 0, 0, 0, 1, 259, 256, 256}};
        vecs[2] = '{0, 'hAA, 'hFF, 0, 256, 0, '{1, 1, 0, 0, 0, 0, 259, 256, 256}};
        vecs[3] = '{0, 'hAA, 'h02, 0, 256, 0, '{0, 0, 0, 1, 0, 0, 259, 256, 256}};
        vecs[4] = '{1, 'hAA, 'h01, 8, 8, 0, '{1, 0, 0, 0, 0, 0, 11, 8, 8}};
        vecs[5] = '{1, 'hAA, 'h01, 2, 8, 0, '{0, 0, 0, 0, 1, 0, 6, 3, 2}};
        vecs[6] = '{1, 'h55, 'h01, 4, 4, 0, '{0, 0, 1, 0, 0, 0, 7, 4, 4}};
        vecs[7] = '{1, 'hAA, 'hFF, 32, 32, 1, '{0, 1, 0, 0, 0, 1, 35, 32, 32}};
        vecs[8] = '{1, 'hAA, 'h01, 33, 33, 0, '{0, 0, 0, 0, 1, 0, 6, 3, 33}};

        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 256; j++) smem[i][j] = 8'h00;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.ctrl", {busy, done, run, bcast, es, ea, el, ec, we}, 0);
        chk("reset.adr", {sa, da, dd}, 0);
        chk("reset.pkt_len", plen, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            build(v.d, v.b0, v.b1, v.b2, v.n, v.bad);
            run_pkt(v.d, v.e, $sformatf("vec%0d", i), 0);
        end

        // start re-pulsed while busy must not spawn a second run
        build(0, 'hAA, 'h01, 0, 256, 0);
        run_pkt(0, vecs[0].e, "busy_ign", 50);

        // reset in the middle of a packet
        build(0, 'hAA, 'h01, 0, 256, 0);
        @(negedge clk) start[0] = 1'b1;
        @(negedge clk) start[0] = 1'b0;
        cyc = 1;
        while (cyc < 100) begin @(negedge clk); cyc++; end
        chk("rst_mid.we_before", we[0], 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.we_after", we[0], 0);
        chk("rst_mid.busy_after", busy[0], 0);
        rst = 1'b0;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (done[0] || run[0] || busy[0] || we[0]) bad++;
        end
        chk("rst_mid.no_done", bad, 0);

        // start coincident with reset
        @(negedge clk) begin rst = 1'b1; start[0] = 1'b1; end
        @(negedge clk) begin rst = 1'b0; start[0] = 1'b0; end
        chk("rst_start.busy", busy[0], 0);
        @(negedge clk);
        chk("rst_start.busy2", busy[0], 0);

        for (int r = 0; r < 12; r++) begin
            d  = (r < 10) ? 1 : 0;
            b0 = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : 'hAA;
            case ($urandom_range(3))
                0: b1 = 'h01;
                1: b1 = 'hFF;
                2: b1 = int'($urandom_range(255));
                default: b1 = 'h01;
            endcase
            L = int'($urandom_range(40));
            n = d ? ((L < 2) ? 2 : L) : 256;
            build(d, b0, b1, L, n, $urandom_range(3) == 0);
            e = model(d);
            run_pkt(d, e, $sformatf("rnd%0d", r), 0);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
